// File: rtl/idct_1d_seq.sv
// idct_1d_seq: sequential 8-point 1-D IDCT/FDCT engine.
//   Accepts one 8-sample vector per valid/ready transfer. Eight MACs run in
//   parallel for eight cycles, consuming one input sample per cycle. The
//   result is then presented under valid/ready.
//   Optional build macro IDCT_SAT_EN: round half up and saturate outputs
//   instead of truncating and wrapping.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   in_valid   input vector valid
//   in_ready   engine idle and able to accept a vector
//   in_mode    0 = IDCT, 1 = FDCT, sampled on accept
//   in_data    x0 in MSBs ... x7 in LSBs, two's complement
//   out_valid  result vector valid
//   out_ready  downstream accepts the result
//   out_data   z0 in MSBs ... z7 in LSBs
module idct_1d_seq #(
   parameter int IN_W   = 12,
   parameter int OUT_W  = 11,
   parameter int COEF_W = 9,
   parameter int ACC_W  = 24,
   parameter int SHIFT  = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_mode,
   input  logic [8*IN_W-1:0]    in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*OUT_W-1:0]   out_data
);

   localparam int PROD_W = IN_W + COEF_W;

   localparam logic signed [COEF_W-1:0] C1 = COEF_W'(251);
   localparam logic signed [COEF_W-1:0] C2 = COEF_W'(236);
   localparam logic signed [COEF_W-1:0] C3 = COEF_W'(213);
   localparam logic signed [COEF_W-1:0] C4 = COEF_W'(181);
   localparam logic signed [COEF_W-1:0] C5 = COEF_W'(142);
   localparam logic signed [COEF_W-1:0] C6 = COEF_W'(98);
   localparam logic signed [COEF_W-1:0] C7 = COEF_W'(50);

   typedef enum logic [1:0] {StIdle, StMac, StFin, StOut} state_t;

   state_t                     state_q;
   logic [2:0]                 cnt_q;
   logic                       mode_q;
   logic [8*IN_W-1:0]          data_q;
   logic signed [ACC_W-1:0]    acc_q   [8];
   logic signed [ACC_W-1:0]    acc_nxt [8];
   logic signed [PROD_W-1:0]   prod    [8];
   logic signed [COEF_W-1:0]   kcoef   [8];
   logic signed [IN_W-1:0]     x_sel;
   logic [8*OUT_W-1:0]         out_nxt;

   // T(k,n) ~ cos((2n+1)k*pi/16), with the angle folded into 0..16 (mod 32)
   function automatic logic signed [COEF_W-1:0] coef(input logic [2:0] k, input logic [2:0] n);
      logic [4:0] m;
      logic [4:0] f;
      logic signed [COEF_W-1:0] c;
      m = {1'b0, n, 1'b1} * {2'b00, k};  // wraps mod 32 by width
      f = (m > 5'd16) ? (5'd0 - m) : m;
      c = '0;
      if (k == 3'd0) begin
         c = C4;
      end else begin
         case (f)
            5'd1:    c = C1;
            5'd2:    c = C2;
            5'd3:    c = C3;
            5'd4:    c = C4;
            5'd5:    c = C5;
            5'd6:    c = C6;
            5'd7:    c = C7;
            5'd9:    c = -C7;
            5'd10:   c = -C6;
            5'd11:   c = -C5;
            5'd12:   c = -C4;
            5'd13:   c = -C3;
            5'd14:   c = -C2;
            5'd15:   c = -C1;
            default: c = '0;
         endcase
      end
      return c;
   endfunction

   // Current sample x[cnt] from the latched vector
   always_comb begin
      x_sel = '0;
      for (int j = 0; j < 8; j++) begin
         if (cnt_q == 3'(j)) x_sel = data_q[(7-j)*IN_W +: IN_W];
      end
   end

   // Eight parallel MACs; IDCT walks the table transposed
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         kcoef[i]   = mode_q ? coef(3'(i), cnt_q) : coef(cnt_q, 3'(i));
         prod[i]    = x_sel * kcoef[i];
         acc_nxt[i] = acc_q[i] + {{(ACC_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
      end
   end

`ifdef IDCT_SAT_EN
   localparam logic signed [ACC_W:0] RndBias = (ACC_W+1)'(2**(SHIFT-1));
   localparam logic signed [ACC_W:0] SatMax  = (ACC_W+1)'(2**(OUT_W-1) - 1);
   localparam logic signed [ACC_W:0] SatMin  = (ACC_W+1)'(-(2**(OUT_W-1)));

   logic signed [ACC_W:0] rnd [8];
   logic signed [ACC_W:0] shf [8];

   // One extra bit keeps the rounding add from wrapping
   always_comb begin
      out_nxt = '0;
      for (int i = 0; i < 8; i++) begin
         rnd[i] = {acc_q[i][ACC_W-1], acc_q[i]} + RndBias;
         shf[i] = rnd[i] >>> SHIFT;
         if (shf[i] > SatMax) begin
            out_nxt[(7-i)*OUT_W +: OUT_W] = SatMax[OUT_W-1:0];
         end else if (shf[i] < SatMin) begin
            out_nxt[(7-i)*OUT_W +: OUT_W] = SatMin[OUT_W-1:0];
         end else begin
            out_nxt[(7-i)*OUT_W +: OUT_W] = shf[i][OUT_W-1:0];
         end
      end
   end
`else
   // Plain bit-slice: floor division by 2^SHIFT, wraps on overflow
   always_comb begin
      out_nxt = '0;
      for (int i = 0; i < 8; i++) begin
         out_nxt[(7-i)*OUT_W +: OUT_W] = acc_q[i][SHIFT+OUT_W-1:SHIFT];
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= 3'd0;
         mode_q    <= 1'b0;
         data_q    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         for (int i = 0; i < 8; i++) acc_q[i] <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  data_q   <= in_data;
                  mode_q   <= in_mode;
                  cnt_q    <= 3'd0;
                  in_ready <= 1'b0;
                  for (int i = 0; i < 8; i++) acc_q[i] <= '0;
                  state_q  <= StMac;
               end
            end
            StMac: begin
               for (int i = 0; i < 8; i++) acc_q[i] <= acc_nxt[i];
               cnt_q <= cnt_q + 3'd1;  // wraps back to 0 after the last sample
               if (cnt_q == 3'd7) state_q <= StFin;
            end
            StFin: begin
               out_data  <= out_nxt;
               out_valid <= 1'b1;
               state_q   <= StOut;
            end
            StOut: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_idct_1d_seq.sv
// tb_idct_1d_seq: directed self-checking bench for idct_1d_seq.
module tb_idct_1d_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_mode;
   logic [95:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [87:0] out_data;

   int n_chk  = 0;
   int n_fail = 0;

`ifdef IDCT_SAT_EN
   localparam int ExpOvf = 1023;
   localparam int ExpFdc = 283;
`else
   localparam int ExpOvf = -739;
   localparam int ExpFdc = 282;
`endif

   idct_1d_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   function automatic logic [95:0] pk_in(input int a0, a1, a2, a3, a4, a5, a6, a7);
      return {12'(a0), 12'(a1), 12'(a2), 12'(a3), 12'(a4), 12'(a5), 12'(a6), 12'(a7)};
   endfunction

   function automatic logic [87:0] pk_out(input int a0, a1, a2, a3, a4, a5, a6, a7);
      return {11'(a0), 11'(a1), 11'(a2), 11'(a3), 11'(a4), 11'(a5), 11'(a6), 11'(a7)};
   endfunction

   // Present a vector and return #1 after the accepting edge
   task automatic send(input logic [95:0] v, input logic m);
      int n;
      n = 0;
      in_data  = v;
      in_mode  = m;
      in_valid = 1'b1;
      while (!in_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      n_chk++;
      if (!in_ready) begin
         n_fail++;
         $display("FAIL send_accept: in_ready=%b required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Cycles from the accepting edge until out_valid is seen
   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 40);
      n_chk++;
      if (!out_valid) begin
         n_fail++;
         $display("FAIL wait_out: out_valid=%b required 1 within 40 cycles", out_valid);
      end
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
      end
      n_chk++;
      if (out_data !== 88'd0) begin
         n_fail++; $display("FAIL reset_out_data: got %h required 0", out_data);
      end
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_dc_idct();
      int lat;
      logic [87:0] exp_z;
      exp_z = pk_out(181, 181, 181, 181, 181, 181, 181, 181);
      out_ready = 1'b1;  // held high while nothing is valid
      send(pk_in(512, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      wait_out(lat);
      n_chk++;
      if (lat !== 9) begin
         n_fail++; $display("FAIL dc_latency: got %0d required 9", lat);
      end
      n_chk++;
      if (out_data !== exp_z) begin
         n_fail++; $display("FAIL dc_idct: got %h required %h", out_data, exp_z);
      end
      n_chk++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL dc_exclusive: in_ready=%b required 0", in_ready);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_chk++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++; $display("FAIL dc_release: valid,ready=%b required 01", {out_valid, in_ready});
      end
   endtask

   task automatic test_neg_dc();
      int lat;
      logic [87:0] exp_z;
      exp_z = pk_out(-181, -181, -181, -181, -181, -181, -181, -181);
      send(pk_in(-512, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      wait_out(lat);
      n_chk++;
      if (out_data !== exp_z) begin
         n_fail++; $display("FAIL neg_dc: got %h required %h", out_data, exp_z);
      end
      take();
   endtask

   task automatic test_overflow();
      int lat;
      logic [10:0] exp_z0;
      exp_z0 = 11'(ExpOvf);
      send(pk_in(2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047), 1'b0);
      wait_out(lat);
      n_chk++;
      if (out_data[87:77] !== exp_z0) begin
         n_fail++; $display("FAIL overflow_z0: got %h required %h", out_data[87:77], exp_z0);
      end
      take();
   endtask

   task automatic test_fdct_dc();
      int lat;
      logic [87:0] exp_z;
      exp_z = pk_out(ExpFdc, 0, 0, 0, 0, 0, 0, 0);
      send(pk_in(100, 100, 100, 100, 100, 100, 100, 100), 1'b1);
      wait_out(lat);
      n_chk++;
      if (out_data !== exp_z) begin
         n_fail++; $display("FAIL fdct_dc: got %h required %h", out_data, exp_z);
      end
      take();
   endtask

   // Mode and data flip right after accept must not disturb the vector in flight
   task automatic test_idct_basis();
      int lat;
      logic [87:0] exp_z;
      exp_z = pk_out(251, 213, 142, 50, -50, -142, -213, -251);
      send(pk_in(0, 512, 0, 0, 0, 0, 0, 0), 1'b0);
      in_mode = 1'b1;
      in_data = pk_in(7, 7, 7, 7, 7, 7, 7, 7);
      wait_out(lat);
      n_chk++;
      if (out_data !== exp_z) begin
         n_fail++; $display("FAIL idct_basis: got %h required %h", out_data, exp_z);
      end
      take();
   endtask

   task automatic test_fdct_basis();
      int lat;
      logic [87:0] exp_z;
      exp_z = pk_out(181, 50, -236, -142, 181, 213, -98, -251);
      send(pk_in(0, 0, 0, 512, 0, 0, 0, 0), 1'b1);
      in_mode = 1'b0;
      wait_out(lat);
      n_chk++;
      if (out_data !== exp_z) begin
         n_fail++; $display("FAIL fdct_basis: got %h required %h", out_data, exp_z);
      end
      take();
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      logic [87:0] exp_z;
      exp_z = pk_out(181, 181, 181, 181, 181, 181, 181, 181);
      bad = 0;
      send(pk_in(512, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      wait_out(lat);
      repeat (20) begin
         @(posedge clk); #1;
         if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, exp_z}) bad++;
      end
      n_chk++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL backpressure_hold: %0d bad cycles, required 0", bad);
      end
      take();
      n_chk++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL backpressure_release: valid,ready=%b required 01", {out_valid, in_ready});
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen;
      logic [87:0] exp_z;
      exp_z = pk_out(181, 181, 181, 181, 181, 181, 181, 181);
      seen = 0;
      send(pk_in(0, 512, 0, 0, 0, 0, 0, 0), 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_chk++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++; $display("FAIL reset_mid: valid,ready=%b required 01", {out_valid, in_ready});
      end
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      n_chk++;
      if (seen !== 0) begin
         n_fail++; $display("FAIL reset_mid_no_output: out_valid seen %0d cycles, required 0", seen);
      end
      send(pk_in(512, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      wait_out(lat);
      n_chk++;
      if (out_data !== exp_z) begin
         n_fail++; $display("FAIL reset_mid_next: got %h required %h", out_data, exp_z);
      end
      take();
   endtask

   task automatic test_back_to_back();
      logic [95:0] vin   [2];
      logic        vmode [2];
      logic [87:0] vexp  [2];
      int both;
      int n;
      vin[0] = pk_in(-512, 0, 0, 0, 0, 0, 0, 0);  vmode[0] = 1'b0;
      vexp[0] = pk_out(-181, -181, -181, -181, -181, -181, -181, -181);
      vin[1] = pk_in(0, 0, 0, 512, 0, 0, 0, 0);   vmode[1] = 1'b1;
      vexp[1] = pk_out(181, 50, -236, -142, 181, 213, -98, -251);
      out_ready = 1'b1;
      for (int v = 0; v < 2; v++) begin
         both = 0;
         n = 0;
         send(vin[v], vmode[v]);
         while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (out_valid && in_ready) both++;
         end
         n_chk++;
         if (out_data !== vexp[v] || !out_valid) begin
            n_fail++; $display("FAIL b2b_data%0d: got %h required %h", v, out_data, vexp[v]);
         end
         n_chk++;
         if (both !== 0) begin
            n_fail++; $display("FAIL b2b_exclusive%0d: %0d overlap cycles, required 0", v, both);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_mode   = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      test_reset();
      test_dc_idct();
      test_neg_dc();
      test_overflow();
      test_fdct_dc();
      test_idct_basis();
      test_fdct_basis();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
